// File: rtl/fir_mac_engine_if.sv
// Sample, coefficient and result signals of the FIR MAC engine.
// The master side feeds samples and coefficients and consumes results.
interface fir_mac_engine_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_mac_engine.sv
// Sequential FIR filter: one multiply-accumulate per tap, then holds the
// result until the consumer takes it. Arithmetic wraps in DW bits.
module fir_mac_engine #(
  parameter int NTAPS = 4,
  parameter int DW    = 8,
  parameter int FRAC  = 7
) (
  input logic              clk,
  input logic              rst_n,
  fir_mac_engine_if.slave  bus
);
  localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic signed [DW-1:0]   x [NTAPS];
  logic signed [DW-1:0]   c [NTAPS];
  logic signed [DW-1:0]   acc;
  logic [AW-1:0]          tap;
  logic                   last_tap;
  logic                   addr_ok;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   p;

  assign last_tap = (tap == AW'(NTAPS - 1));
  assign addr_ok  = ({1'b0, bus.coef_addr} < (AW + 1)'(NTAPS));

  // Full-width product, floored by the arithmetic shift, then wrapped to DW bits
  assign prod = (2*DW)'(x[tap]) * (2*DW)'(c[tap]);
  assign p    = DW'(prod >>> FRAC);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = MAC;
      MAC:     if (last_tap) state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coefficient writes land on the edge, so a same-cycle MAC read sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      tap <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      if (bus.coef_we && addr_ok) c[bus.coef_addr] <= bus.coef_data;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = NTAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0] <= bus.in_data;
            acc  <= '0;
            tap  <= '0;
          end
        end
        MAC: begin
          acc <= acc + p;
          tap <= last_tap ? '0 : tap + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: transaction-level reference model with a
// per-cycle compare process, directed literal cases and random traffic.
module tb_fir_mac_engine;
  localparam int NTAPS = 4;
  localparam int DW    = 8;
  localparam int FRAC  = 7;
  localparam int AW    = $clog2(NTAPS);

  logic clk = 1'b0;
  logic rst_n;

  fir_mac_engine_if #(.DW(DW), .AW(AW)) bus();

  fir_mac_engine #(.NTAPS(NTAPS), .DW(DW), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: sample history, coefficients, and the transaction in flight
  int mx [NTAPS];
  int mc [NTAPS];
  bit mBusy;
  bit mHold;
  int mStep;
  int mAcc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wrapDw(input int v);
    int m;
    m = v & ((1 << DW) - 1);
    if (m >= (1 << (DW - 1))) m = m - (1 << DW);
    return m;
  endfunction

  function automatic int scaledProduct(input int a, input int b);
    return wrapDw((a * b) >>> FRAC);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // A sample accepted at edge E takes its k-th product at edge E+1+k, using
  // the coefficient as it stood before that edge; the result is then held until taken.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        for (int k = 0; k < NTAPS; k++) begin
          mx[k] = 0;
          mc[k] = 0;
        end
        mBusy = 0;
        mHold = 0;
        mStep = 0;
        mAcc  = 0;
      end else begin
        if (mHold) begin
          if (bus.out_ready) mHold = 0;
        end else if (mBusy) begin
          mAcc = wrapDw(mAcc + scaledProduct(mx[mStep], mc[mStep]));
          mStep++;
          if (mStep == NTAPS) begin
            mBusy = 0;
            mHold = 1;
          end
        end else if (bus.in_valid) begin
          for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
          mx[0] = int'(bus.in_data);
          mAcc  = 0;
          mStep = 0;
          mBusy = 1;
        end
        if (bus.coef_we && int'(bus.coef_addr) < NTAPS) mc[bus.coef_addr] = int'(bus.coef_data);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("model_in_ready", int'(bus.in_ready), int'(!mBusy && !mHold));
        check("model_out_valid", int'(bus.out_valid), int'(mHold));
        if (mHold) check("model_out_data", int'(bus.out_data), mAcc);
      end
    end
  end

  task automatic writeCoef(input int addr, input int data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = AW'(addr);
    bus.coef_data = DW'(data);
    @(negedge clk);
    bus.coef_we   = 1'b0;
  endtask

  task automatic loadCoefs(input int c0, input int c1, input int c2, input int c3);
    writeCoef(0, c0);
    writeCoef(1, c1);
    writeCoef(2, c2);
    writeCoef(3, c3);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int sample, output int acceptCyc);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(sample);
    acceptCyc    = cyc + 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int expected, input int acceptCyc);
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_valid"}, int'(bus.out_valid), 1);
    check({name, "_latency"}, cyc - acceptCyc, NTAPS);
    check({name, "_data"}, int'(bus.out_data), expected);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    @(negedge clk);
    doReset();

    $display("[TB] half-gain filter");
    loadCoefs(64, 64, 0, 0);
    applyStimulus(100, a);
    checkOutput("half_gain_0", 50, a);
    applyStimulus(20, a);
    checkOutput("half_gain_1", 60, a);

    $display("[TB] impulse response");
    doReset();
    loadCoefs(20, -40, 60, -80);
    applyStimulus(64, a);
    checkOutput("impulse_0", 10, a);
    applyStimulus(0, a);
    checkOutput("impulse_1", -20, a);
    applyStimulus(0, a);
    checkOutput("impulse_2", 30, a);
    applyStimulus(0, a);
    checkOutput("impulse_3", -40, a);

    $display("[TB] accumulator wrap");
    doReset();
    loadCoefs(127, 127, 127, 127);
    applyStimulus(127, a);
    checkOutput("wrap_0", 126, a);
    applyStimulus(127, a);
    checkOutput("wrap_1", -4, a);
    applyStimulus(127, a);
    checkOutput("wrap_2", 122, a);
    applyStimulus(127, a);
    checkOutput("wrap_3", -8, a);

    $display("[TB] output backpressure");
    doReset();
    loadCoefs(64, 64, 0, 0);
    bus.out_ready = 1'b0;
    applyStimulus(100, a);
    for (int w = 0; w < 40 && !bus.out_valid; w++) @(negedge clk);
    check("bp_latency", cyc - a, NTAPS);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_data", int'(bus.out_data), 50);
      check("bp_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = (k % 2 == 0);
      bus.in_data  = DW'(77);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_ready", int'(bus.in_ready), 1);
    applyStimulus(20, a);
    checkOutput("bp_after", 60, a);

    $display("[TB] reset during accumulation");
    applyStimulus(100, a);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_in_ready", int'(bus.in_ready), 1);
    check("midreset_out_data", int'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("midreset_no_output", int'(bus.out_valid), 0);
      @(negedge clk);
    end
    loadCoefs(64, 64, 0, 0);
    applyStimulus(100, a);
    checkOutput("midreset_after", 50, a);

    $display("[TB] coefficient write collision");
    doReset();
    loadCoefs(64, 64, 0, 0);
    applyStimulus(100, a);
    checkOutput("collide_first", 50, a);
    applyStimulus(20, a);
    @(negedge clk);
    writeCoef(1, 0);
    checkOutput("collide_old_coef", 60, a);
    applyStimulus(40, a);
    checkOutput("collide_new_coef", 20, a);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = DW'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.coef_we   = ($urandom_range(0, 4) == 0);
      bus.coef_addr = AW'($urandom);
      bus.coef_data = DW'($urandom);
      if (i == 1500) begin
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
